// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch address generator.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_e;

    // Entry fields are sized for the largest supported configuration
    // (ADDR_W <= 64, FETCH_BYTES <= 16); narrower builds leave the upper bits
    // constant zero so synthesis trims them away.
    localparam int ENT_ADDR_W = 64;
    localparam int ENT_DATA_W = 128;
    localparam int ENT_OFF_W  = 4;

    // Wide enough for any count in 0..8.
    localparam int CNT_W = 4;

    typedef struct packed {
        logic [ENT_ADDR_W-1:0] addr;
        logic [ENT_DATA_W-1:0] data;
        logic [ENT_OFF_W-1:0]  offset;
    } fetch_entry_t;

    localparam int ENT_W = $bits(fetch_entry_t);

    function automatic int clog2_f(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    // Byte-offset width within one fetch word.
    function automatic int off_w(input int fetch_bytes);
        return clog2_f(fetch_bytes);
    endfunction

endpackage

// File: rtl/fetch_addr_gen_fifo.sv
// Response buffer between the memory interface and the fetch consumer.
// Depth equals the credit limit, so the producer never pushes into a full buffer.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [ENT_W-1:0] wdata_i,
    input  logic             pop_i,
    output logic [ENT_W-1:0] rdata_o,
    output logic [CNT_W-1:0] count_o,
    output logic             valid_o
);

    localparam int PTR_W = (DEPTH > 1) ? clog2_f(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             pop_ok;

    assign pop_ok  = pop_i && (count_q != '0);
    assign valid_o = (count_q != '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Pointer and occupancy tracking; flush empties the buffer in one cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
            if (pop_ok) rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_ok);
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/fetch_addr_gen.sv
// Sequential instruction fetch address generator with credit-based flow
// control, redirect handling with stale-response discard, and a response
// buffer that tags each word with its address and entry byte offset.
module fetch_addr_gen
    import fetch_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                FETCH_BYTES = 4,
    parameter int                MAX_OUTST   = 2,
    parameter logic [ADDR_W-1:0] BOOT_ADDR   = ADDR_W'(32'h0000_0080)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          en_i,
    input  logic                          redirect_i,
    input  logic [ADDR_W-1:0]             redirect_addr_i,
    output logic                          req_o,
    output logic [ADDR_W-1:0]             addr_o,
    input  logic                          gnt_i,
    input  logic                          rvalid_i,
    input  logic [8*FETCH_BYTES-1:0]      rdata_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [ADDR_W-1:0]             out_addr_o,
    output logic [8*FETCH_BYTES-1:0]      out_data_o,
    output logic [off_w(FETCH_BYTES)-1:0] out_offset_o
);

    localparam int OFF_W = off_w(FETCH_BYTES);
    localparam logic [CNT_W:0] CREDIT_MAX = (CNT_W + 1)'(MAX_OUTST);

    function automatic logic [ADDR_W-1:0] align_addr(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    endfunction

    fetch_state_e state_q, state_d;

    logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
    logic [ADDR_W-1:0] resp_addr_q, resp_addr_d;
    logic [OFF_W-1:0]  pend_off_q, pend_off_d;
    logic              first_q, first_d;
    logic [CNT_W-1:0]  outst_q, outst_d;
    logic [CNT_W-1:0]  disc_q, disc_d;

    logic              gnt_fire;
    logic              push;
    logic              pop;
    logic              resp_consumed;
    logic [CNT_W-1:0]  in_flight;
    logic [CNT_W-1:0]  fifo_cnt;
    logic [CNT_W-1:0]  fifo_cnt_d;
    logic              fifo_valid;
    logic              credit_nxt;
    fetch_entry_t      push_entry;
    fetch_entry_t      head;
    logic              unused_head;

    assign gnt_fire      = req_o && gnt_i;
    assign pop           = fifo_valid && out_ready_i;
    assign in_flight     = disc_q + outst_q;
    assign resp_consumed = rvalid_i && (in_flight != '0);

    // Address, offset and in-flight bookkeeping for grants, responses and redirects.
    always_comb begin
        fetch_addr_d = fetch_addr_q;
        resp_addr_d  = resp_addr_q;
        pend_off_d   = pend_off_q;
        first_d      = first_q;
        outst_d      = outst_q;
        disc_d       = disc_q;
        push         = 1'b0;
        if (redirect_i) begin
            // Everything already requested, including a same-cycle grant,
            // belongs to the old stream; a same-cycle response is dropped.
            fetch_addr_d = align_addr(redirect_addr_i);
            resp_addr_d  = align_addr(redirect_addr_i);
            pend_off_d   = redirect_addr_i[OFF_W-1:0];
            first_d      = 1'b1;
            outst_d      = '0;
            disc_d       = in_flight + CNT_W'(gnt_fire) - CNT_W'(resp_consumed);
        end else begin
            // Responses retire stale requests first since memory answers in order.
            if (rvalid_i && (disc_q != '0)) begin
                disc_d = disc_q - CNT_W'(1);
            end else if (rvalid_i && (outst_q != '0)) begin
                outst_d     = outst_q - CNT_W'(1);
                push        = 1'b1;
                resp_addr_d = resp_addr_q + ADDR_W'(FETCH_BYTES);
                first_d     = 1'b0;
            end
            if (gnt_fire) begin
                outst_d      = outst_d + CNT_W'(1);
                fetch_addr_d = fetch_addr_q + ADDR_W'(FETCH_BYTES);
            end
        end
    end

    // Occupancy after this cycle; used so a freed slot re-enables requests next cycle.
    always_comb begin
        fifo_cnt_d = fifo_cnt + CNT_W'(push) - CNT_W'(pop);
        if (redirect_i) fifo_cnt_d = '0;
        credit_nxt = ({1'b0, outst_d} + {1'b0, disc_d} + {1'b0, fifo_cnt_d}) < CREDIT_MAX;
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // FSM next state; once raised, the request is only withdrawn by a grant.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (en_i && credit_nxt) state_d = ST_REQ;
            ST_REQ: begin
                if (gnt_i) begin
                    if (!en_i)           state_d = ST_IDLE;
                    else if (!credit_nxt) state_d = ST_HOLD;
                end
            end
            // With enable low HOLD behaves like IDLE, so no separate exit is needed.
            ST_HOLD: if (en_i && credit_nxt) state_d = ST_REQ;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        req_o  = (state_q == ST_REQ);
        addr_o = fetch_addr_q;
    end

    // Datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_addr_q <= align_addr(BOOT_ADDR);
            resp_addr_q  <= align_addr(BOOT_ADDR);
            pend_off_q   <= BOOT_ADDR[OFF_W-1:0];
            first_q      <= 1'b1;
            outst_q      <= '0;
            disc_q       <= '0;
        end else begin
            fetch_addr_q <= fetch_addr_d;
            resp_addr_q  <= resp_addr_d;
            pend_off_q   <= pend_off_d;
            first_q      <= first_d;
            outst_q      <= outst_d;
            disc_q       <= disc_d;
        end
    end

    // Buffer entry for the response being accepted this cycle.
    always_comb begin
        push_entry        = '0;
        push_entry.addr   = ENT_ADDR_W'(resp_addr_q);
        push_entry.data   = ENT_DATA_W'(rdata_i);
        push_entry.offset = first_q ? ENT_OFF_W'(pend_off_q) : '0;
    end

    fetch_fifo #(
        .DEPTH (MAX_OUTST)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (redirect_i),
        .push_i  (push),
        .wdata_i (push_entry),
        .pop_i   (pop),
        .rdata_o (head),
        .count_o (fifo_cnt),
        .valid_o (fifo_valid)
    );

    // Head presentation; fields read as zero while the buffer is empty.
    always_comb begin
        out_valid_o  = fifo_valid;
        out_addr_o   = fifo_valid ? head.addr[ADDR_W-1:0] : '0;
        out_data_o   = fifo_valid ? head.data[8*FETCH_BYTES-1:0] : '0;
        out_offset_o = fifo_valid ? head.offset[OFF_W-1:0] : '0;
    end

    assign unused_head = ^head;

endmodule

// File: tb/tb_fetch_addr_gen.sv
module tb_fetch_addr_gen;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        en_i;
    logic        redirect_i;
    logic [31:0] redirect_addr_i;
    logic        req_o;
    logic [31:0] addr_o;
    logic        gnt_i;
    logic        rvalid_i;
    logic [31:0] rdata_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_addr_o;
    logic [31:0] out_data_o;
    logic [1:0]  out_offset_o;

    always #5 clk_i = ~clk_i;

    fetch_addr_gen dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .en_i            (en_i),
        .redirect_i      (redirect_i),
        .redirect_addr_i (redirect_addr_i),
        .req_o           (req_o),
        .addr_o          (addr_o),
        .gnt_i           (gnt_i),
        .rvalid_i        (rvalid_i),
        .rdata_i         (rdata_i),
        .out_valid_o     (out_valid_o),
        .out_ready_i     (out_ready_i),
        .out_addr_o      (out_addr_o),
        .out_data_o      (out_data_o),
        .out_offset_o    (out_offset_o)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [1:0]  o;
    } ent_t;

    logic [31:0] exp_gnt[$];
    ent_t        exp_out[$];
    logic [31:0] resp_q[$];
    bit          auto_resp;
    int          n_cmp;
    int          n_err;

    function automatic logic [31:0] dfun(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_3C3C;
    endfunction

    function automatic ent_t mk(input logic [31:0] a, input logic [1:0] o);
        ent_t r;
        r.a = a;
        r.d = dfun(a);
        r.o = o;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check the handshakes of the current cycle, cross the
    // edge, then drive the memory responder for the next cycle.
    task automatic tick();
        logic [31:0] ea;
        ent_t        eo;
        if (req_o && gnt_i) begin
            n_cmp++;
            assert (exp_gnt.size() != 0) else begin
                n_err++;
                $error("FAIL unexpected_grant: observed addr %0h expected no grant", addr_o);
            end
            if (exp_gnt.size() != 0) begin
                ea = exp_gnt.pop_front();
                chk("grant_addr", addr_o, ea);
                if (auto_resp) resp_q.push_back(ea);
            end
        end
        if (out_valid_o && out_ready_i) begin
            n_cmp++;
            assert (exp_out.size() != 0) else begin
                n_err++;
                $error("FAIL unexpected_out: observed addr %0h data %0h expected no output",
                       out_addr_o, out_data_o);
            end
            if (exp_out.size() != 0) begin
                eo = exp_out.pop_front();
                chk("out_addr", out_addr_o, eo.a);
                chk("out_data", out_data_o, eo.d);
                chk("out_offset", out_offset_o, eo.o);
            end
        end
        @(posedge clk_i);
        @(negedge clk_i);
        if (auto_resp) begin
            if (resp_q.size() != 0) begin
                ea       = resp_q.pop_front();
                rvalid_i = 1'b1;
                rdata_i  = dfun(ea);
            end else begin
                rvalid_i = 1'b0;
            end
        end
    endtask

    task automatic drain_gnt(input string tag);
        int n;
        n = 0;
        while (exp_gnt.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        n_cmp++;
        assert (exp_gnt.size() == 0) else begin
            n_err++;
            $error("FAIL %s: observed %0d grants pending expected 0", tag, exp_gnt.size());
        end
    endtask

    task automatic drain_out(input string tag);
        int n;
        n = 0;
        while (exp_out.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        n_cmp++;
        assert (exp_out.size() == 0) else begin
            n_err++;
            $error("FAIL %s: observed %0d outputs pending expected 0", tag, exp_out.size());
        end
    endtask

    task automatic redirect(input logic [31:0] a);
        redirect_i      = 1'b1;
        redirect_addr_i = a;
        tick();
        redirect_i      = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        auto_resp       = 1'b0;
        rst_ni          = 1'b1;
        en_i            = 1'b0;
        redirect_i      = 1'b0;
        redirect_addr_i = '0;
        gnt_i           = 1'b0;
        rvalid_i        = 1'b0;
        rdata_i         = '0;
        out_ready_i     = 1'b1;
        #1 rst_ni = 1'b0;

        // Reset values
        repeat (2) @(negedge clk_i);
        chk("rst_req", req_o, 0);
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_addr", addr_o, 32'h80);
        chk("rst_out_addr", out_addr_o, 0);
        chk("rst_out_data", out_data_o, 0);
        chk("rst_out_offset", out_offset_o, 0);
        en_i  = 1'b1;
        gnt_i = 1'b1;
        @(negedge clk_i);
        chk("rst_req_en", req_o, 0);

        // Boot fetch stream with grant tied high and 1-cycle responses
        rst_ni    = 1'b1;
        auto_resp = 1'b1;
        exp_gnt.push_back(32'h80);
        exp_gnt.push_back(32'h84);
        exp_gnt.push_back(32'h88);
        exp_out.push_back(mk(32'h80, 2'd0));
        exp_out.push_back(mk(32'h84, 2'd0));
        exp_out.push_back(mk(32'h88, 2'd0));
        drain_gnt("boot_grants");
        gnt_i = 1'b0;
        en_i  = 1'b0;
        drain_out("boot_out");

        // Ungranted request stays up with a stable address even with enable low
        for (int i = 0; i < 3; i++) begin
            chk("hold_req", req_o, 1);
            chk("hold_addr", addr_o, 32'h8C);
            tick();
        end

        // Misaligned redirect
        en_i = 1'b1;
        redirect(32'h0000_1003);
        chk("redir_addr", addr_o, 32'h1000);
        chk("redir_req", req_o, 1);
        exp_gnt.push_back(32'h1000);
        exp_gnt.push_back(32'h1004);
        exp_out.push_back(mk(32'h1000, 2'd3));
        exp_out.push_back(mk(32'h1004, 2'd0));
        gnt_i = 1'b1;
        drain_gnt("redir_grants");
        gnt_i = 1'b0;
        drain_out("redir_out");

        // Address wrap at the top of the address space
        redirect(32'hFFFF_FFFC);
        chk("wrap_first_addr", addr_o, 32'hFFFF_FFFC);
        exp_gnt.push_back(32'hFFFF_FFFC);
        exp_gnt.push_back(32'h0000_0000);
        exp_out.push_back(mk(32'hFFFF_FFFC, 2'd0));
        exp_out.push_back(mk(32'h0000_0000, 2'd0));
        gnt_i = 1'b1;
        drain_gnt("wrap_grants");
        gnt_i = 1'b0;
        drain_out("wrap_out");

        // Redirect with two outstanding and a coincident response: both stale words dropped
        auto_resp = 1'b0;
        redirect(32'h2000);
        exp_gnt.push_back(32'h2000);
        exp_gnt.push_back(32'h2004);
        gnt_i = 1'b1;
        drain_gnt("stale_grants");
        gnt_i = 1'b0;
        chk("stale_hold_req", req_o, 0);
        rvalid_i = 1'b1;
        rdata_i  = 32'hDEAD_0000;
        redirect(32'h3000);
        rdata_i  = 32'hDEAD_0004;
        tick();
        rvalid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("stale_no_out", out_valid_o, 0);
            tick();
        end
        auto_resp = 1'b1;
        exp_gnt.push_back(32'h3000);
        exp_out.push_back(mk(32'h3000, 2'd0));
        gnt_i = 1'b1;
        drain_gnt("new_grant");
        gnt_i = 1'b0;
        drain_out("new_out");

        // Back-pressure: credit limit of two grants, one pop reopens requests
        out_ready_i = 1'b0;
        redirect(32'h4000);
        exp_gnt.push_back(32'h4000);
        exp_gnt.push_back(32'h4004);
        exp_out.push_back(mk(32'h4000, 2'd0));
        exp_out.push_back(mk(32'h4004, 2'd0));
        gnt_i = 1'b1;
        repeat (10) tick();
        chk("bp_grants_left", exp_gnt.size(), 0);
        chk("bp_hold_req", req_o, 0);
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        chk("bp_req_back", req_o, 1);
        exp_gnt.push_back(32'h4008);
        exp_out.push_back(mk(32'h4008, 2'd0));
        tick();
        gnt_i = 1'b0;
        out_ready_i = 1'b1;
        drain_out("bp_out");

        // Reset mid-operation with two outstanding
        auto_resp = 1'b0;
        redirect(32'h5000);
        exp_gnt.push_back(32'h5000);
        exp_gnt.push_back(32'h5004);
        gnt_i = 1'b1;
        drain_gnt("mid_grants");
        gnt_i  = 1'b0;
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_req", req_o, 0);
        chk("mid_rst_out_valid", out_valid_o, 0);
        chk("mid_rst_addr", addr_o, 32'h80);
        @(negedge clk_i);
        rst_ni   = 1'b1;
        rvalid_i = 1'b1;
        rdata_i  = 32'hBAD0_0000;
        tick();
        tick();
        rvalid_i = 1'b0;
        tick();
        chk("late_resp_ignored", out_valid_o, 0);
        auto_resp = 1'b1;
        exp_gnt.push_back(32'h80);
        exp_out.push_back(mk(32'h80, 2'd0));
        gnt_i = 1'b1;
        drain_gnt("restart_grant");
        gnt_i = 1'b0;
        drain_out("restart_out");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_addr_gen.md
FETCH_ADDR_GEN -- requirements
Module: fetch_addr_gen

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width in bits.
REQ-002 SHALL have parameter FETCH_BYTES, default 4, bytes per fetch; power of two, 2..16.
REQ-003 SHALL have parameter MAX_OUTST, default 2, maximum fetches in flight plus buffered; 1..8.
REQ-004 SHALL have parameter BOOT_ADDR, default 32'h0000_0080, first fetch target after reset.
REQ-005 SHALL have port clk_i, input, 1, single clock; all state on its rising edge.
REQ-006 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port en_i, input, 1, fetch enable.
REQ-008 SHALL have ports redirect_i (input, 1) and redirect_addr_i (input, ADDR_W), the new fetch target, any byte alignment.
REQ-009 SHALL have ports req_o (output, 1), addr_o (output, ADDR_W) and gnt_i (input, 1), the memory request handshake.
REQ-010 SHALL have ports rvalid_i (input, 1) and rdata_i (input, 8*FETCH_BYTES), in-order memory responses.
REQ-011 SHALL have ports out_valid_o (output, 1), out_ready_i (input, 1), out_addr_o (output, ADDR_W), out_data_o (output, 8*FETCH_BYTES) and out_offset_o (output, OFF_W = log2(FETCH_BYTES)).

Function
REQ-012 addr_o SHALL always be aligned: {fetch_addr[ADDR_W-1:OFF_W], OFF_W'b0}.
REQ-013 FSM SHALL have states IDLE (no req), REQ (req_o=1) and HOLD (no credit).
- IDLE->REQ: en_i=1 and credit available.
- REQ->HOLD: gnt with no remaining credit.
- REQ->IDLE: gnt with en_i=0.
- HOLD->REQ: credit freed and en_i=1.
REQ-014 Credit SHALL exist when outstanding + discard + FIFO occupancy < MAX_OUTST.
REQ-015 While req_o=1 and gnt_i=0, addr_o SHALL hold stable and req_o SHALL stay high even if en_i falls; only redirect_i may alter it.
REQ-016 On gnt_i, fetch_addr SHALL advance by FETCH_BYTES modulo 2^ADDR_W, and outstanding SHALL increment.
REQ-017 redirect_i at cycle t SHALL, at t+1:
- set fetch_addr to aligned redirect_addr_i;
- move all outstanding to the discard count;
- flush the FIFO;
- set pending offset = redirect_addr_i[OFF_W-1:0].
REQ-018 A request granted in the same cycle as redirect_i SHALL be counted as discard.
REQ-019 rvalid_i with discard > 0 SHALL decrement discard and push nothing; discard SHALL take priority over outstanding.
REQ-020 A non-discarded rvalid_i SHALL push {addr, data, offset} into the FIFO; offset SHALL be the pending offset for the first push after redirect/reset, else 0.
REQ-021 rvalid_i coinciding with redirect_i SHALL be discarded.
REQ-022 rvalid_i with zero outstanding and zero discard SHALL be ignored.
REQ-023 out_* SHALL present the FIFO head; it SHALL be popped on out_valid_o && out_ready_i.
REQ-024 FIFO push and pop in the same cycle SHALL be legal; credit accounting SHALL make overflow impossible.
REQ-025 Latency SHALL be gnt_i to earliest out_valid_o equal to response latency + 1 cycle (registered FIFO write).

Reset
REQ-026 Reset SHALL set:
- fetch_addr = aligned BOOT_ADDR;
- pending offset = BOOT_ADDR[OFF_W-1:0];
- state = IDLE;
- outstanding, discard and FIFO pointers = 0.
REQ-027 While in reset: req_o=0, out_valid_o=0, addr_o = aligned BOOT_ADDR, out_addr_o/out_data_o/out_offset_o = 0.
REQ-028 Reset mid-operation SHALL drop all in-flight state; responses arriving after reset release SHALL be ignored per REQ-022.

Structure
REQ-029 Shared package fetch_pkg SHALL hold the FSM state enum, the FIFO entry struct type and the OFF_W/clog2 helper function.
REQ-030 Sub-module fetch_fifo (synchronous, depth MAX_OUTST, flush input) SHALL implement the buffer.

Verification
REQ-031 Reset release, en_i=1, gnt_i tied 1, 1-cycle rvalid -> addr_o 0x80, 0x84, 0x88; first out_offset_o=0.
REQ-032 redirect_i with addr 0x1003 -> next addr_o 0x1000; first out entry out_addr_o=0x1000, out_offset_o=3; following entry 0x1004, offset 0.
REQ-033 redirect_i to 0xFFFF_FFFC, continuous gnt -> addr_o 0xFFFF_FFFC then 0x0000_0000.
REQ-034 Two outstanding, then redirect_i together with rvalid_i -> both old responses discarded; no out_valid_o until the new target's data arrives.
REQ-035 out_ready_i=0, MAX_OUTST=2 -> exactly 2 grants, then req_o=0 (HOLD); one pop -> req_o reasserts next cycle.
REQ-036 rst_ni pulsed low with 2 outstanding -> req_o=0 and out_valid_o=0 immediately; late rvalid_i ignored; fetch restarts at 0x80.
